// File: rtl/lpc_post_fifo.sv
// lpc_post_fifo
//
// Services the I/O read/write handshake of the upstream LPC peripheral FSM.
// Codes written to BASE_ADDR are pushed into a FIFO that drains through a
// valid/ready stream. A status register is readable at BASE_ADDR+1.
//
// Optional feature macro: LPC_POST_OVF_CNT_EN
//   When defined, an 8-bit saturating count of dropped pushes is readable at
//   BASE_ADDR+2, cleared by reset and by a BASE_ADDR+1 write with bit0 set.
//   When undefined, BASE_ADDR+2 is unmapped and reads 8'hFF.
//
// Ports
//   clk_i          LPC clock
//   rst_i          synchronous reset, active high
//   lpc_data_io    write data from the FSM / read data driven by this block
//   lpc_addr_i     I/O address from the FSM
//   lpc_data_wr_i  write data valid (level)
//   lpc_wr_done_o  write consumed, held until lpc_data_wr_i falls
//   lpc_data_req_i read request: rise = request, fall = data taken
//   lpc_data_rd_o  read data valid on lpc_data_io
//   post_data_o    FIFO head
//   post_valid_o   FIFO not empty
//   post_ready_i   consumer pops head when valid & ready
//   fifo_level_o   entries stored, 0..FIFO_DEPTH
//   overflow_o     sticky: push attempted while full

module lpc_post_fifo #(
  parameter logic [15:0] BASE_ADDR  = 16'h0080,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LVL_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  inout  wire  [7:0]       lpc_data_io,
  input  logic [15:0]      lpc_addr_i,
  input  logic             lpc_data_wr_i,
  output logic             lpc_wr_done_o,
  input  logic             lpc_data_req_i,
  output logic             lpc_data_rd_o,
  output logic [7:0]       post_data_o,
  output logic             post_valid_o,
  input  logic             post_ready_i,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             overflow_o
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0]      STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ACK,
    ST_RD_DRIVE
  } state_e;

  state_e             state_q;
  logic               wr_done_q;
  logic               rd_valid_q;
  logic [7:0]         rd_reg_q;
  logic [7:0]         last_code_q;
  logic               overflow_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

`ifdef LPC_POST_OVF_CNT_EN
  localparam logic [15:0] CNT_ADDR = BASE_ADDR + 16'd2;
  logic [7:0]         ovf_cnt_q;
`endif

  // Decode of the current bus cycle. A write or read only executes on the
  // IDLE edge that first sees the strobe; write wins over a simultaneous read.
  logic       wr_exec;
  logic       hit_code;
  logic       hit_stat;
  logic       push_req;
  logic       flush;
  logic       ovf_clr;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  logic [6:0] lvl_sat;
  logic [7:0] rd_data_d;

  assign wr_exec  = (state_q == ST_IDLE) && lpc_data_wr_i;
  assign hit_code = (lpc_addr_i == BASE_ADDR);
  assign hit_stat = (lpc_addr_i == STAT_ADDR);
  assign push_req = wr_exec && hit_code;
  assign flush    = wr_exec && hit_stat && lpc_data_io[1];
  assign ovf_clr  = wr_exec && hit_stat && lpc_data_io[0];
  assign full     = (level_q == FULL_LVL);
  // Flush takes priority over a same-cycle pop.
  assign pop      = post_valid_o && post_ready_i && !flush;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Status register reports the level saturated into 7 bits.
  always_comb begin
    lvl_sat = 7'h7F;
    if (int'(level_q) < 128) lvl_sat = 7'(level_q);
  end

  // Read data mux; anything unmapped reads all ones.
  always_comb begin
    rd_data_d = 8'hFF;
    if (hit_code) begin
      rd_data_d = last_code_q;
    end else if (hit_stat) begin
      rd_data_d = {overflow_q, lvl_sat};
    end
`ifdef LPC_POST_OVF_CNT_EN
    else if (lpc_addr_i == CNT_ADDR) begin
      rd_data_d = ovf_cnt_q;
    end
`endif
  end

  // Handshake FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_reg_q    <= 8'h00;
      last_code_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lpc_data_wr_i) begin
            if (hit_code) last_code_q <= lpc_data_io;
            wr_done_q <= 1'b1;
            state_q   <= ST_WR_ACK;
          end else if (lpc_data_req_i) begin
            rd_reg_q   <= rd_data_d;
            rd_valid_q <= 1'b1;
            state_q    <= ST_RD_DRIVE;
          end
        end
        ST_WR_ACK: begin
          if (!lpc_data_wr_i) begin
            wr_done_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_RD_DRIVE: begin
          if (!lpc_data_req_i) begin
            rd_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          wr_done_q  <= 1'b0;
          rd_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO control state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  // NOTE: storage is not reset; entries are only observable once the level
  // says they were written, so resetting them would buy nothing.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= lpc_data_io;
  end

`ifdef LPC_POST_OVF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || ovf_clr) begin
      ovf_cnt_q <= 8'h00;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end
`endif

  // The bus is only driven while read data is being presented.
  assign lpc_data_io   = rd_valid_q ? rd_reg_q : 8'hzz;
  assign lpc_wr_done_o = wr_done_q;
  assign lpc_data_rd_o = rd_valid_q;
  assign post_valid_o  = (level_q != '0);
  assign post_data_o   = mem_q[rd_ptr_q];
  assign fifo_level_o  = level_q;
  assign overflow_o    = overflow_q;

endmodule
